hazard_scheduler: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Takes each D-stage instruction's decoded Tuse/Tnew and register addresses, and keeps a scoreboard of in-flight writers in E, M and W.
- Issues the D-stage stall (freeze F/D, bubble into E) and the forwarding-mux selects for D, E and M operand consumers.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_scheduler.sv | 137 +++++++++++++
 tb/tb_hazard_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// MIPS 5-stage hazard unit: E/M/W writer scoreboard, D-stage stall, D/E/M forward selects.
// Stall and selects are combinational in the current cycle; the scoreboard advances every clock.
module hazard_scheduler #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] A1_D,
  input  logic [REG_AW-1:0] A2_D,
  input  logic [1:0]        Tuse_rs_D,
  input  logic [1:0]        Tuse_rt_D,
  input  logic [REG_AW-1:0] A3_D,
  input  logic [1:0]        Tnew_D,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [1:0]        fwd_rt_M,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] a1_e_q, a1_e_d, a2_e_q, a2_e_d, a3_e_q, a3_e_d;
  logic [1:0]        tnew_e_q, tnew_e_d;
  logic [REG_AW-1:0] a2_m_q, a2_m_d, a3_m_q, a3_m_d;
  logic [1:0]        tnew_m_q, tnew_m_d;
  logic [REG_AW-1:0] a3_w_q, a3_w_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              stall_rs, stall_rt;

  // The nearest matching writer decides; an E match shadows any older M writer.
  function automatic logic need_stall(input logic [REG_AW-1:0] a, input logic [1:0] tuse,
                                      input logic [REG_AW-1:0] a3_e, input logic [1:0] tnew_e,
                                      input logic [REG_AW-1:0] a3_m, input logic [1:0] tnew_m);
    logic r;
    r = 1'b0;
    if (a != '0) begin
      if (a == a3_e)      r = (tnew_e > tuse);
      else if (a == a3_m) r = (tnew_m > tuse);
    end
    return r;
  endfunction

  function automatic logic [1:0] sel_d(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] a3_e, input logic [1:0] tnew_e,
                                       input logic [REG_AW-1:0] a3_m, input logic [1:0] tnew_m,
                                       input logic [REG_AW-1:0] a3_w);
    logic [1:0] r;
    r = 2'd0;
    if (a != '0) begin
      if (a == a3_e)      r = (tnew_e == 2'd0) ? 2'd1 : 2'd0;
      else if (a == a3_m) r = (tnew_m == 2'd0) ? 2'd2 : 2'd0;
      else if (a == a3_w) r = 2'd3;
    end
    return r;
  endfunction

  // A pending M writer hides W, same as the D-stage rule.
  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] a3_m, input logic [1:0] tnew_m,
                                       input logic [REG_AW-1:0] a3_w);
    logic [1:0] r;
    r = 2'd0;
    if (a != '0) begin
      if (a == a3_m)      r = (tnew_m == 2'd0) ? 2'd2 : 2'd0;
      else if (a == a3_w) r = 2'd3;
    end
    return r;
  endfunction

  always_comb begin
    stall_rs = need_stall(A1_D, Tuse_rs_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_rt = need_stall(A2_D, Tuse_rt_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall    = stall_rs | stall_rt;

    fwd_rs_D = sel_d(A1_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    fwd_rt_D = sel_d(A2_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    fwd_rs_E = sel_e(a1_e_q, a3_m_q, tnew_m_q, a3_w_q);
    fwd_rt_E = sel_e(a2_e_q, a3_m_q, tnew_m_q, a3_w_q);
    fwd_rt_M = ((a2_m_q != '0) && (a2_m_q == a3_w_q)) ? 2'd3 : 2'd0;
    stall_cnt = stall_cnt_q;
  end

  always_comb begin
    a1_e_d   = A1_D;
    a2_e_d   = A2_D;
    a3_e_d   = A3_D;
    tnew_e_d = Tnew_D;
    if (stall || flush) begin
      a1_e_d   = '0;
      a2_e_d   = '0;
      a3_e_d   = '0;
      tnew_e_d = 2'd0;
    end

    a2_m_d   = a2_e_q;
    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
    if (flush) begin
      a2_m_d   = '0;
      a3_m_d   = '0;
      tnew_m_d = 2'd0;
    end

    a3_w_d = a3_m_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_e_q      <= '0;
      a2_e_q      <= '0;
      a3_e_q      <= '0;
      tnew_e_q    <= '0;
      a2_m_q      <= '0;
      a3_m_q      <= '0;
      tnew_m_q    <= '0;
      a3_w_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      a1_e_q      <= a1_e_d;
      a2_e_q      <= a2_e_d;
      a3_e_q      <= a3_e_d;
      tnew_e_q    <= tnew_e_d;
      a2_m_q      <= a2_m_d;
      a3_m_q      <= a3_m_d;
      tnew_m_q    <= tnew_m_d;
      a3_w_q      <= a3_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Cycle-by-cycle vectors for hazard_scheduler; a narrow stall counter exposes saturation quickly.
module tb_hazard_scheduler;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    a1_d, a2_d, a3_d;
  logic [1:0]    tuse_rs_d, tuse_rt_d, tnew_d;
  logic          flush;
  logic          stall;
  logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [CW-1:0] stall_cnt;

  hazard_scheduler #(.CNT_W(CW), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .A1_D(a1_d), .A2_D(a2_d), .Tuse_rs_D(tuse_rs_d), .Tuse_rt_D(tuse_rt_d),
    .A3_D(a3_d), .Tnew_D(tnew_d), .flush(flush),
    .stall(stall), .fwd_rs_D(fwd_rs_d), .fwd_rt_D(fwd_rt_d),
    .fwd_rs_E(fwd_rs_e), .fwd_rt_E(fwd_rt_e), .fwd_rt_M(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    a1;
    logic [1:0]    tu_rs;
    logic [4:0]    a2;
    logic [1:0]    tu_rt;
    logic [4:0]    a3;
    logic [1:0]    tnew;
    logic          fl;
    logic          rst;
    logic          st;
    logic [1:0]    frsd, frtd, frse, frte, frtm;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vi = 0;

  function automatic vec_t mk(int a1, int tu_rs, int a2, int tu_rt, int a3, int tnew, int fl, int rst,
                              int st, int frsd, int frtd, int frse, int frte, int frtm, int cnt);
    vec_t r;
    r.a1 = 5'(a1);   r.tu_rs = 2'(tu_rs); r.a2 = 5'(a2); r.tu_rt = 2'(tu_rt);
    r.a3 = 5'(a3);   r.tnew = 2'(tnew);   r.fl = 1'(fl); r.rst = 1'(rst);
    r.st = 1'(st);   r.frsd = 2'(frsd);   r.frtd = 2'(frtd);
    r.frse = 2'(frse); r.frte = 2'(frte); r.frtm = 2'(frtm); r.cnt = CW'(cnt);
    return r;
  endfunction

  function automatic vec_t nop(int cnt);
    return mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, vi, act, exp);
    end
  endtask

  // Drive just after the rising edge, score at the falling edge, return on the next rising edge.
  task automatic step(input vec_t v);
    vec_t e;
    #1;
    a1_d = v.a1; tuse_rs_d = v.tu_rs; a2_d = v.a2; tuse_rt_d = v.tu_rt;
    a3_d = v.a3; tnew_d = v.tnew; flush = v.fl; reset = v.rst;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty vec %0d", vi);
    end else begin
      e = exp_q.pop_front();
      chk("stall",     32'(stall),     32'(e.st));
      chk("fwd_rs_D",  32'(fwd_rs_d),  32'(e.frsd));
      chk("fwd_rt_D",  32'(fwd_rt_d),  32'(e.frtd));
      chk("fwd_rs_E",  32'(fwd_rs_e),  32'(e.frse));
      chk("fwd_rt_E",  32'(fwd_rt_e),  32'(e.frte));
      chk("fwd_rt_M",  32'(fwd_rt_m),  32'(e.frtm));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
    vi++;
    @(posedge clk);
  endtask

  initial begin
    // reset state
    tbl.push_back(nop(0));
    // load-use: lw $2 then addu rs=$2
    tbl.push_back(mk(0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
    tbl.push_back(nop(1)); tbl.push_back(nop(1));
    // branch after ALU: addu $3 then beq $3,$0
    tbl.push_back(mk(0, 3, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // shadowing with a nop gap: lui in M wins over ori in W
    tbl.push_back(mk(0, 3, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(2));
    tbl.push_back(mk(4, 1, 0, 1, 7, 1, 0, 0, 0, 2, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // back-to-back shadowing: E lui hides M ori, then fwd_rs_E = 2 from lui
    tbl.push_back(mk(0, 3, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(4, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // jal then jr $31
    tbl.push_back(mk(0, 3, 0, 3, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(31, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // store data: lw $5 then sw rt=$5
    tbl.push_back(mk(0, 3, 0, 3, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // register 0: writer to $0 then Tuse 0 reader of $0
    tbl.push_back(mk(0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // rt paths: writer $8, gap, reader rt=$8
    tbl.push_back(mk(0, 3, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(nop(2));
    tbl.push_back(mk(0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2));
    tbl.push_back(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2));
    tbl.push_back(nop(2)); tbl.push_back(nop(2));
    // flush during a load-use stall
    tbl.push_back(mk(0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(2, 1, 0, 1, 6, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(2, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(nop(3)); tbl.push_back(nop(3)); tbl.push_back(nop(3)); tbl.push_back(nop(3));

    reset = 1'b1; flush = 1'b0;
    a1_d = '0; a2_d = '0; a3_d = '0; tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_d = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) step(tbl[i]);

    // two-cycle stall with the counter already at all-ones: it must hold
    step(mk(0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    step(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    step(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3));
    step(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 3));
    step(nop(3)); step(nop(3)); step(nop(3));

    // reset asserted mid-stall: the next cycle is empty and the counter cleared
    step(mk(0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    step(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3));
    step(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(nop(0));

    // counting restarts from zero after reset
    step(mk(0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(2, 1, 0, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(2, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1));
    step(nop(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
